// File: rtl/aes_decrypt_mode_ctrl_pkg.sv
// aes_decrypt_mode_ctrl_pkg: shared AES block width, chaining-mode and FSM state encodings
package aes_decrypt_mode_ctrl_pkg;
  localparam int BLK_W = 128;
  typedef enum logic [2:0] {
    MODE_ECB = 3'd0,
    MODE_CBC = 3'd1,
    MODE_CFB = 3'd2,
    MODE_OFB = 3'd3,
    MODE_CTR = 3'd4
  } aes_mode_e;
  typedef enum logic [1:0] {IDLE, WAIT_IN, RUN, HOLD_OUT} aes_state_e;
  function automatic logic mode_ok(input logic [2:0] m);
    return m <= 3'(MODE_CTR);
  endfunction
endpackage

// File: rtl/aes_core_watchdog.sv
// aes_core_watchdog: counts cycles spent waiting on the block-cipher core
// Ports: clk, reset (async active-low); arm = waiting on core, clear = restart
// count, done = core answered; expired = last allowed cycle passed without done.
module aes_core_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic arm,
  input  logic clear,
  input  logic done,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = (clear || !arm || done) ? '0 : cnt_q + CW'(1);
  end
  // fires on the TIMEOUT-th armed cycle so the caller leaves after exactly TIMEOUT cycles
  assign expired = arm && !done && cnt_q == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/aes_decrypt_mode_ctrl.sv
// aes_decrypt_mode_ctrl: ECB/CBC/CFB/OFB/CTR decrypt chaining around an external block-cipher core
// Ports: clk, reset (async active-low); start/mode/iv open a stream;
// in_valid/in_ready/ciphertext and out_valid/out_ready/plaintext are block handshakes;
// core_start/core_enc_dec/core_in/core_out/core_done drive the cipher core;
// busy = stream open, err = sticky error (bad mode or core timeout).
module aes_decrypt_mode_ctrl
  import aes_decrypt_mode_ctrl_pkg::*;
#(
  parameter int CORE_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [BLK_W-1:0] iv,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] ciphertext,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] plaintext,
  output logic             core_start,
  output logic             core_enc_dec,
  output logic [BLK_W-1:0] core_in,
  input  logic [BLK_W-1:0] core_out,
  input  logic             core_done,
  output logic             busy,
  output logic             err
);
  aes_state_e state_q, state_d;
  logic [2:0] mode_q, mode_d;
  logic [BLK_W-1:0] c_q, c_d, fb_q, fb_d, ctr_q, ctr_d, pt_q, pt_d;
  logic err_q, err_d, cs_q, cs_d, expired, dec_path;
  assign dec_path = mode_q == MODE_ECB || mode_q == MODE_CBC;
  aes_core_watchdog #(.TIMEOUT(CORE_TIMEOUT)) u_wd (
    .clk(clk),
    .reset(reset),
    .arm(state_q == RUN),
    .clear(state_q == WAIT_IN),
    .done(core_done),
    .expired(expired)
  );
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    c_d = c_q;
    fb_d = fb_q;
    ctr_d = ctr_q;
    pt_d = pt_q;
    err_d = err_q;
    cs_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = mode_ok(mode) ? WAIT_IN : IDLE;
        err_d = !mode_ok(mode);
        mode_d = mode_ok(mode) ? mode : mode_q;
        fb_d = mode_ok(mode) ? iv : fb_q;
        ctr_d = mode_ok(mode) ? iv : ctr_q;
      end
      WAIT_IN: if (in_valid) begin
        c_d = ciphertext;
        cs_d = 1'b1;
        state_d = RUN;
      end
      RUN: if (core_done) begin
        state_d = HOLD_OUT;
        // CBC whitens with the previous ciphertext (fb before its update); stream modes with C
        pt_d = mode_q == MODE_ECB ? core_out : mode_q == MODE_CBC ? core_out ^ fb_q : core_out ^ c_q;
        fb_d = (mode_q == MODE_CBC || mode_q == MODE_CFB) ? c_q : mode_q == MODE_OFB ? core_out : fb_q;
        ctr_d = mode_q == MODE_CTR ? ctr_q + BLK_W'(1) : ctr_q;
      end else if (expired) begin
        state_d = IDLE;
        err_d = 1'b1;
      end
      HOLD_OUT: if (out_ready) state_d = WAIT_IN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mode_q <= '0;
      c_q <= '0;
      fb_q <= '0;
      ctr_q <= '0;
      pt_q <= '0;
      err_q <= 1'b0;
      cs_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      c_q <= c_d;
      fb_q <= fb_d;
      ctr_q <= ctr_d;
      pt_q <= pt_d;
      err_q <= err_d;
      cs_q <= cs_d;
    end
  end
  assign in_ready = state_q == WAIT_IN;
  assign out_valid = state_q == HOLD_OUT;
  assign busy = state_q != IDLE;
  assign err = err_q;
  assign plaintext = pt_q;
  assign core_start = cs_q;
  // outside a stream the core is left in encrypt direction
  assign core_enc_dec = state_q == IDLE || !dec_path;
  assign core_in = dec_path ? c_q : mode_q == MODE_CTR ? ctr_q : fb_q;
endmodule

// File: tb/tb_aes_decrypt_mode_ctrl.sv
// tb_aes_decrypt_mode_ctrl: randomized round-trip bench with toy cipher core and mode encryption model
module tb_aes_decrypt_mode_ctrl;
  localparam logic [127:0] KEY    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
  logic clk = 0, reset = 0, start = 0, in_valid = 0, out_ready, core_done;
  logic [2:0] mode = 0;
  logic [127:0] iv = 0, ciphertext = 0, core_out;
  logic in_ready, out_valid, core_start, core_enc_dec, busy, err;
  logic [127:0] plaintext, core_in;
  int total = 0, bad = 0;
  logic [127:0] exp_q[$], pq[$], cin_log[$];
  logic enc_log[$];
  bit core_hold = 0, rdy_rand = 0, rdy_fix = 1;

  aes_decrypt_mode_ctrl #(.CORE_TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .iv(iv),
    .in_valid(in_valid), .in_ready(in_ready), .ciphertext(ciphertext),
    .out_valid(out_valid), .out_ready(out_ready), .plaintext(plaintext),
    .core_start(core_start), .core_enc_dec(core_enc_dec), .core_in(core_in),
    .core_out(core_out), .core_done(core_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] enc_f(input logic [127:0] x);
    return {x[120:0], x[127:121]} ^ KEY;
  endfunction
  function automatic logic [127:0] dec_f(input logic [127:0] y);
    logic [127:0] t;
    t = y ^ KEY;
    return {t[6:0], t[127:7]};
  endfunction
  function automatic logic [127:0] core_f(input logic e, input logic [127:0] x);
    return e ? enc_f(x) : (x == FIPS_C ? FIPS_P : dec_f(x));
  endfunction

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask

  // cipher core: answers 1..4 cycles after core_start unless held
  initial begin
    int pend;
    logic [127:0] c_in;
    logic c_enc;
    pend = 0; c_in = 0; c_enc = 1;
    core_done = 0; core_out = 0;
    forever begin
      @(posedge clk); #1;
      if (!reset) begin
        pend = 0;
        core_done = 0;
      end else begin
        core_done = 0;
        if (core_start) begin
          cin_log.push_back(core_in);
          enc_log.push_back(core_enc_dec);
          c_in = core_in; c_enc = core_enc_dec;
          pend = core_hold ? -1 : int'($urandom_range(1, 4));
        end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            core_done = 1;
            core_out = core_f(c_enc, c_in);
          end
        end
      end
    end
  end

  initial begin
    out_ready = 0;
    forever begin
      @(posedge clk); #2;
      out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fix;
    end
  end

  // compare process: every output handshake against the model queue, plus hold/exclusion rules
  initial begin
    bit prev_hold;
    logic [127:0] prev_pt, e;
    prev_hold = 0; prev_pt = 0;
    forever begin
      @(negedge clk);
      if (!reset) prev_hold = 0;
      else begin
        if (prev_hold) begin
          total++;
          if (!out_valid || plaintext !== prev_pt) begin
            bad++;
            $display("FAIL hold_stable got=%b/%h want=1/%h", out_valid, plaintext, prev_pt);
          end
        end
        total++;
        if (in_ready && out_valid) begin
          bad++;
          $display("FAIL ready_excl got in_ready=1 out_valid=1 want not both");
        end
        if (out_valid && out_ready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_out got=%h want none", plaintext);
          end else begin
            e = exp_q.pop_front();
            if (plaintext !== e) begin
              bad++;
              $display("FAIL plaintext got=%h want=%h", plaintext, e);
            end
          end
        end
        prev_hold = out_valid && !out_ready;
        prev_pt = plaintext;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); #3;
    reset = 0; in_valid = 0; start = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    #3 reset = 1;
    @(negedge clk);
  endtask

  task automatic do_start(input logic [2:0] m, input logic [127:0] v);
    start = 1; mode = m; iv = v;
    @(negedge clk);
    start = 0;
  endtask

  task automatic send(input logic [127:0] c);
    int n;
    n = 0;
    in_valid = 1; ciphertext = c;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 128'(exp_q.size()), 0);
  endtask

  // encrypts pq under mode m with the textbook chaining rules, expects pq back from the DUT
  task automatic run_stream(input logic [2:0] m, input logic [127:0] v);
    logic [127:0] c[$];
    logic [127:0] prev, p, ci;
    int n;
    prev = v;
    n = pq.size();
    for (int i = 0; i < n; i++) begin
      p = pq[i];
      case (m)
        3'd0: ci = enc_f(p);
        3'd1: begin ci = enc_f(p ^ prev); prev = ci; end
        3'd2: begin ci = p ^ enc_f(prev); prev = ci; end
        3'd3: begin prev = enc_f(prev); ci = p ^ prev; end
        default: ci = p ^ enc_f(v + 128'(i));
      endcase
      c.push_back(ci);
      exp_q.push_back(p);
    end
    do_start(m, v);
    for (int i = 0; i < n; i++) send(c[i]);
    drain();
    if (m >= 3'd1 && m <= 3'd3) chk("fb_final", dut.fb_q, prev);
    if (m == 3'd4) chk("ctr_final", dut.ctr_q, v + 128'(n));
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout got=running want=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [127:0] pt0;
    // reset state while reset is held low
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_plaintext", plaintext, 0);
    chk("rst_enc_dec", core_enc_dec, 1);
    chk("rst_fb", dut.fb_q, 0);
    chk("rst_ctr", dut.ctr_q, 0);
    @(negedge clk); #3 reset = 1;
    @(negedge clk);
    // pin the toy core model with hand-computed values
    chk("model_e1", enc_f(128'h1), 128'h000102030405060708090a0b0c0d0e8f);
    chk("model_d", dec_f(KEY), 0);

    // ECB with the FIPS-197 vector
    rdy_rand = 0; rdy_fix = 1;
    cin_log.delete(); enc_log.delete();
    exp_q.push_back(FIPS_P);
    do_start(3'd0, 0);
    chk("ecb_busy", busy, 1);
    send(FIPS_C);
    drain();
    chk("fips_starts", 128'(enc_log.size()), 1);
    if (enc_log.size() > 0) begin
      chk("fips_enc_dec", enc_log[0], 0);
      chk("fips_core_in", cin_log[0], FIPS_C);
    end

    // CBC round trip with the SP800-38A plaintexts
    do_reset();
    pq = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
           128'h30c81c46a35ce411e5fbc1191a0a52ef};
    run_stream(3'd1, 128'h000102030405060708090a0b0c0d0e0f);

    // CTR counter wrap
    do_reset();
    cin_log.delete(); enc_log.delete();
    pq = '{128'h1, 128'h2};
    run_stream(3'd4, '1);
    chk("wrap_starts", 128'(cin_log.size()), 2);
    if (cin_log.size() >= 2) begin
      chk("wrap_cin0", cin_log[0], '1);
      chk("wrap_cin1", cin_log[1], 0);
      chk("wrap_enc0", enc_log[0], 1);
      chk("wrap_enc1", enc_log[1], 1);
    end

    // randomized streams over all modes with random backpressure and core latency
    for (int it = 0; it < 15; it++) begin
      do_reset();
      rdy_rand = 1;
      pq.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++)
        pq.push_back({$urandom, $urandom, $urandom, $urandom});
      run_stream(3'($urandom_range(0, 4)), {$urandom, $urandom, $urandom, $urandom});
    end

    // backpressure: output held 10 cycles while the next block waits
    do_reset();
    rdy_rand = 0; rdy_fix = 0;
    exp_q.push_back(128'h1111);
    exp_q.push_back(128'h2222);
    do_start(3'd0, 0);
    send(enc_f(128'h1111));
    for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
    chk("bp_out_valid", out_valid, 1);
    in_valid = 1; ciphertext = enc_f(128'h2222);
    pt0 = plaintext;
    chk("bp_pt_first", pt0, 128'h1111);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("bp_pt", plaintext, pt0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_core_start", core_start, 0);
    end
    rdy_fix = 1;
    send(enc_f(128'h2222));
    drain();

    // errors: bad mode, ignored start, core timeout
    do_reset();
    do_start(3'd6, 0);
    chk("bad_err", err, 1);
    chk("bad_busy", busy, 0);
    do_start(3'd2, 128'h55);
    chk("ok_err_clr", err, 0);
    chk("ok_busy", busy, 1);
    do_start(3'd6, 0);
    chk("ign_err", err, 0);
    chk("ign_busy", busy, 1);
    core_hold = 1;
    send(128'h1234);
    repeat (60) @(negedge clk);
    chk("to_busy_early", busy, 1);
    chk("to_err_early", err, 0);
    repeat (10) @(negedge clk);
    chk("to_busy", busy, 0);
    chk("to_err", err, 1);
    chk("to_in_ready", in_ready, 0);

    // reset in the middle of RUN
    do_reset();
    do_start(3'd1, 128'h99);
    send(128'habcd);
    @(negedge clk);
    chk("mid_busy", busy, 1);
    #3 reset = 0;
    #1;
    chk("mid_in_ready", in_ready, 0);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_core_start", core_start, 0);
    chk("mid_busy_rst", busy, 0);
    chk("mid_err", err, 0);
    chk("mid_pt", plaintext, 0);
    chk("mid_enc_dec", core_enc_dec, 1);
    chk("mid_fb", dut.fb_q, 0);
    chk("mid_ctr", dut.ctr_q, 0);
    repeat (2) @(negedge clk);
    #3 reset = 1;
    core_hold = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("post_out_valid", out_valid, 0);
      chk("post_in_ready", in_ready, 0);
    end
    rdy_rand = 1;
    pq = '{128'hdeadbeef, 128'hcafef00d};
    run_stream(3'd3, 128'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/aes_decrypt_mode_ctrl.md
AES_DECRYPT_MODE_CTRL -- requirements
Module: aes_decrypt_mode_ctrl

Interface
REQ-001 SHALL have parameter CORE_TIMEOUT, default 64, giving the maximum cycles to wait for core_done after core_start.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, a one-cycle pulse that latches mode and iv and opens a new stream.
REQ-005 SHALL have port mode, input, 3, chaining mode: 0 ECB, 1 CBC, 2 CFB, 3 OFB, 4 CTR.
REQ-006 SHALL have port iv, input, 128, IV or initial counter.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1) and ciphertext (input, 128), forming the ciphertext block handshake.
REQ-008 SHALL have ports out_valid (output, 1), out_ready (input, 1) and plaintext (output, 128), forming the plaintext block handshake.
REQ-009 SHALL have ports core_start (output, 1), core_enc_dec (output, 1; 1 = encrypt, 0 = decrypt), core_in (output, 128), core_out (input, 128) and core_done (input, 1), forming the block-cipher core interface.
REQ-010 SHALL have ports busy (output, 1) and err (output, 1), for stream active and sticky error.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT_IN, RUN, HOLD_OUT.
REQ-012 SHALL make these transitions:
- IDLE to WAIT_IN on start with a valid mode.
- WAIT_IN to RUN on in_valid and in_ready.
- RUN to HOLD_OUT on core_done.
- HOLD_OUT to WAIT_IN on out_valid and out_ready.
REQ-013 SHALL assert in_ready only in WAIT_IN and out_valid only in HOLD_OUT; busy is high in every state except IDLE.
REQ-014 SHALL capture ciphertext on input acceptance and pulse core_start for exactly one cycle, the first cycle of RUN.
REQ-015 SHALL drive core_in and core_enc_dec as follows:
- ECB and CBC: C with decrypt.
- CFB and OFB: fb with encrypt.
- CTR: ctr with encrypt.
REQ-016 SHALL register plaintext on core_done as follows:
- ECB: core_out.
- CBC: core_out XOR fb.
- CFB, OFB and CTR: core_out XOR C.
REQ-017 SHALL update state on core_done as follows:
- CBC and CFB: fb <= C.
- OFB: fb <= core_out.
- CTR: ctr <= ctr+1 modulo 2^128, so all-ones wraps to zero.
REQ-018 SHALL give a minimum latency of 3 cycles plus core latency from input acceptance to out_valid.
REQ-019 SHALL hold plaintext and out_valid stable until out_ready, and accept no new input in the meantime.
REQ-020 SHALL on start with mode 5-7 set err and remain in IDLE.
REQ-021 SHALL ignore start outside IDLE.
REQ-022 SHALL in RUN, after CORE_TIMEOUT cycles without core_done, set err and go to IDLE.
REQ-023 SHALL let err clear only on reset or an accepted valid start.
REQ-024 SHALL ignore core_done outside RUN.
REQ-025 SHALL on out_valid and out_ready with in_valid high in the same cycle accept the input no earlier than the next cycle.

Reset
REQ-026 SHALL on reset low immediately force:
- state IDLE;
- in_ready, out_valid, core_start, busy and err to 0;
- plaintext, fb and ctr to 0;
- core_enc_dec to 1.
REQ-027 SHALL on reset mid-block discard the block, emit no output, and require start before new input.

Structure
REQ-028 SHALL take the mode encodings, FSM state encodings and the 128-bit block width from the shared AES package already used by the encrypt path.
REQ-029 SHALL place the timeout counter in one sub-module, aes_core_watchdog (inputs: arm, clear, done; output: expired).
REQ-030 SHALL be core-agnostic, working with the dummy core and the real core unchanged.

Verification
REQ-031 SHALL cover ECB: key-dependent core model with the FIPS-197 vector; ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext 00112233445566778899aabbccddeeff, core_enc_dec=0.
REQ-032 SHALL cover CBC: round-trip three SP800-38A blocks encrypted by aes_encrypt_top with the same IV -> the original plaintexts in order; fb equals the last ciphertext.
REQ-033 SHALL cover CTR wrap: iv all-ones, two blocks -> core_in is FF..FF then 00..00, core_enc_dec=1 on both.
REQ-034 SHALL cover backpressure: out_ready low for 10 cycles -> plaintext stable, in_ready 0 throughout, and no core_start.
REQ-035 SHALL cover errors: start with mode=6 -> err=1 and busy=0; core_done withheld 64 cycles -> err=1 and state IDLE.
REQ-036 SHALL cover reset mid-RUN: out_valid never rises, all outputs are at reset values, and the next start/block runs correctly.
